rs232_ser: RTL and testbench
============================

// Module: rs232_ser
// PURPOSE
//  Byte-to-serial RS-232 transmitter: transmit-side counterpart of rs232_des.
//  Accepts one byte per req/ack handshake and shifts it out as one frame: start, 8 data bits LSB first, stop bit(s).
//  Frame polarity matches rs232_des: idle/stop = IDLE_LVL, start = ~IDLE_LVL, data bits uninverted.
//  Sits between the command/response logic and the UART pin driver.
// PARAMETERS
//  CLK_FREQ      100000000  clk frequency in Hz
//  BAUD_RATE     9600       line bit rate in baud
//  STOP_BITS     1          stop bits per frame; legal values 1 or 2
//  IDLE_LVL      1'b0       line level for idle and stop; start bit = ~IDLE_LVL
//  CLKS_PER_BIT (localparam) CLK_FREQ/BAUD_RATE, integer-truncated (10416 at defaults)
// PORTS
//  clk      in   1  system clock, rising edge
//  rst_n    in   1  asynchronous active-low reset
//  tx_data  in   8  byte to send; must be stable while tx_req=1 and tx_ack=0
//  tx_req   in   1  upstream has a byte on tx_data
//  tx_ack   out  1  one-cycle pulse: tx_data captured, upstream may change it
//  tx       out  1  serial line, driven from a flop (glitch-free)
//  tx_busy  out  1  high from capture until the last stop-bit cycle ends
// BEHAVIOUR
//  Reset (async, any state): tx=IDLE_LVL, tx_ack=0, tx_busy=0, state=IDLE, counters=0, shift reg=0.
//   Frame in flight is abandoned; line returns to idle immediately. No ack for a byte not yet captured.
//  FSM: IDLE -> START -> DATA -> STOP -> IDLE, or STOP -> START on back-to-back.
//  IDLE: tx=IDLE_LVL. On an edge with tx_req=1:
//   latch tx_data into the shift reg, tx_ack=1 for exactly that cycle, tx=~IDLE_LVL, tx_busy=1, enter START.
//  START: hold tx for CLKS_PER_BIT cycles; baud counter runs 0..CLKS_PER_BIT-1; on terminal count enter DATA.
//  DATA: tx=shift[0]; each terminal count shifts right, bit index 0..7; after bit 7 enter STOP, tx=IDLE_LVL.
//  STOP: hold IDLE_LVL for STOP_BITS*CLKS_PER_BIT cycles. At the final terminal count:
//   tx_req=1: capture the next byte exactly as in IDLE (ack pulse, start level next cycle, no idle gap).
//   tx_req=0: enter IDLE, tx_busy=0.
//  Timing:
//   Ack-to-first-start-level latency is 0 cycles; both are registered on the same edge.
//   Frame length = (9+STOP_BITS)*CLKS_PER_BIT cycles exactly.
//  tx_req while busy (outside the final STOP cycle): ignored, no ack, no effect on the current frame.
//  Handshake: upstream drops or updates tx_req/tx_data on the cycle after tx_ack.
//   A tx_req still high at frame end is treated as a new byte (intended streaming mode).
//  Counters: baud counter width $clog2(CLKS_PER_BIT), resets to 0 at each bit boundary, never wraps past terminal.
//   Bit index is 3 bits.
//  tx_data is ignored except on the capture edge.
// TESTING
//  Use CLK_FREQ=100e6, BAUD_RATE=9600 (10416 clk/bit).
//  1. Reset release, tx_req=0 for 20000 cycles -> tx stays 0, tx_busy=0, tx_ack never pulses.
//  2. tx_data=8'hAA, tx_req pulse -> one tx_ack; line reads 1,0,1,0,1,0,1,0,1,0 per bit time (start, LSB..MSB, stop).
//     tx_busy low after 104160 cycles.
//  3. 8'hAA then 8'h55 with tx_req held high -> two acks exactly 104160 cycles apart, no idle gap.
//     Loopback into rs232_des recovers AA then 55.
//  4. tx_req raised mid-frame, then dropped before the stop bit ends -> no ack, frame unchanged, IDLE afterwards.
//  5. rst_n=0 during data bit 3 of 8'hFF -> tx=0 within the same cycle, tx_busy=0;
//     after release with tx_req=0 the line stays idle.
//  6. STOP_BITS=2, byte 8'h5A -> frame 11*10416 cycles; stop level held 20832 cycles; rs232_des decodes 5A.

Source files
------------

// File: rtl/rs232_ser.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_ser
//  Description : Byte-to-serial RS-232 transmitter. One byte is accepted per
//                tx_req/tx_ack handshake and sent as a single frame: a start
//                bit, 8 data bits LSB first, then STOP_BITS stop bits.
//                The line idles at IDLE_LVL and the start bit is ~IDLE_LVL.
//                A request still pending at the end of the final stop bit is
//                accepted immediately, so frames can stream with no idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs232_ser #(
    parameter int   CLK_FREQ  = 100000000,
    parameter int   BAUD_RATE = 9600,
    parameter int   STOP_BITS = 1,
    parameter logic IDLE_LVL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_req,
    output logic       tx_ack,
    output logic       tx,
    output logic       tx_busy
);

    localparam int               CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int               CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST    = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             w_bit_end;

    // The baud counter has reached the last cycle of the current bit period.
    assign w_bit_end = (cnt_q == CNT_LAST);

    // Next-state and next-output logic. idx_q counts data bits in DATA and
    // stop bits in STOP, so two stop bits need no extra counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        ack_d   = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                tx_d   = IDLE_LVL;
                busy_d = 1'b0;
                if (tx_req) begin
                    shift_d = tx_data;
                    ack_d   = 1'b1;
                    tx_d    = ~IDLE_LVL;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (w_bit_end) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (w_bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        tx_d    = IDLE_LVL;
                        state_d = ST_STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        idx_d   = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_STOP: begin
                if (w_bit_end) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        idx_d = 3'd0;
                        if (tx_req) begin
                            // Back-to-back: capture exactly as from IDLE.
                            shift_d = tx_data;
                            ack_d   = 1'b1;
                            tx_d    = ~IDLE_LVL;
                            busy_d  = 1'b1;
                            state_d = ST_START;
                        end else begin
                            tx_d    = IDLE_LVL;
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                tx_d    = IDLE_LVL;
                busy_d  = 1'b0;
                cnt_d   = '0;
                idx_d   = 3'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame and idles the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= IDLE_LVL;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign tx      = tx_q;
    assign tx_ack  = ack_q;
    assign tx_busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rs232_ser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs232_ser
//  Description : Self-checking bench for rs232_ser. Two instances share clock
//                and reset: one with one stop bit, one with two. Expected
//                bytes are queued when driven and popped when a frame is
//                sampled on the line.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs232_ser;

    localparam int N = 10;   // clocks per bit: 1 MHz / 100 kbaud

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data1, data2;
    logic       req1, req2;
    logic       ack1, ack2, tx1, tx2, busy1, busy2;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         nack1    = 0;
    int         nack2    = 0;
    logic [7:0] sb_q[$];

    rs232_ser #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .STOP_BITS(1), .IDLE_LVL(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(data1), .tx_req(req1),
        .tx_ack(ack1), .tx(tx1), .tx_busy(busy1));

    rs232_ser #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .STOP_BITS(2), .IDLE_LVL(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(data2), .tx_req(req2),
        .tx_ack(ack2), .tx(tx2), .tx_busy(busy2));

    always #5 clk = ~clk;

    // Free-running cycle count and ack pulse counters.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ack1 === 1'b1) nack1 <= nack1 + 1;
        if (ack2 === 1'b1) nack2 <= nack2 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic line(input int sel);
        return (sel == 1) ? tx1 : tx2;
    endfunction

    function automatic logic busy(input int sel);
        return (sel == 1) ? busy1 : busy2;
    endfunction

    function automatic logic ack(input int sel);
        return (sel == 1) ? ack1 : ack2;
    endfunction

    // Present a byte at a negedge; returns 1 ns after the capture edge.
    task automatic send(input int sel, input logic [7:0] b, input bit hold);
        @(negedge clk);
        if (sel == 1) begin data1 = b; req1 = 1'b1; end
        else          begin data2 = b; req2 = 1'b1; end
        sb_q.push_back(b);
        @(posedge clk); #1;
        chk("cap_ack",  ack(sel),  1'b1);
        chk("cap_tx",   line(sel), 1'b1);
        chk("cap_busy", busy(sel), 1'b1);
        if (!hold) begin
            if (sel == 1) begin req1 = 1'b0; data1 = ~b; end
            else          begin req2 = 1'b0; data2 = ~b; end
        end
    endtask

    // Called 1 ns after a capture edge: checks every bit at its midpoint, that
    // busy holds through the very last stop cycle, and returns 1 ns after the
    // edge that ends the frame. req_on/req_off raise/drop req1 mid-frame.
    task automatic check_frame(input int sel, input int req_on, input int req_off);
        logic [7:0] d;
        int         nb;
        logic       exp;
        d  = sb_q.pop_front();
        nb = (sel == 1) ? 10 : 11;
        repeat (N / 2) @(posedge clk); #1;
        for (int k = 0; k < nb; k++) begin
            if (k == 0)      exp = 1'b1;
            else if (k <= 8) begin exp = d[0]; d = d >> 1; end
            else             exp = 1'b0;
            chk($sformatf("s%0d_bit%0d", sel, k), line(sel), exp);
            if (k == req_on)  begin req1 = 1'b1; data1 = 8'hFF; end
            if (k == req_off) begin req1 = 1'b0; end
            if (k < nb - 1) begin repeat (N) @(posedge clk); #1; end
        end
        repeat (N - N / 2 - 1) @(posedge clk); #1;
        chk($sformatf("s%0d_busy_last", sel), busy(sel), 1'b1);
        chk($sformatf("s%0d_stop_last", sel), line(sel), 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        int bad;
        int t0;
        rst_n = 1'b0;
        req1 = 1'b0; req2 = 1'b0;
        data1 = 8'h00; data2 = 8'h00;

        // 1. Reset state, then a long idle with no request.
        #3;
        chk("rst_tx1",   tx1,   1'b0);
        chk("rst_busy1", busy1, 1'b0);
        chk("rst_ack1",  ack1,  1'b0);
        chk("rst_tx2",   tx2,   1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (tx1 !== 1'b0 || busy1 !== 1'b0 || tx2 !== 1'b0 || busy2 !== 1'b0) bad++;
        end
        chk("idle_line", bad, 0);
        chk("idle_nack", nack1 + nack2, 0);

        // 2. Single 8'hAA frame.
        send(1, 8'hAA, 1'b0);
        check_frame(1, -1, -1);
        chk("aa_busy_end", busy1, 1'b0);
        chk("aa_nack",     nack1, 1);

        // 3. 8'hAA then 8'h55 with tx_req held high: no idle gap.
        send(1, 8'hAA, 1'b1);
        t0 = cyc;
        data1 = 8'h55;
        sb_q.push_back(8'h55);
        check_frame(1, -1, -1);
        chk("b2b_ack",   ack1, 1'b1);
        chk("b2b_tx",    tx1,  1'b1);
        chk("b2b_gap",   cyc - t0, 10 * N);
        req1 = 1'b0; data1 = 8'h00;
        check_frame(1, -1, -1);
        chk("b2b_busy_end", busy1, 1'b0);
        chk("b2b_nack",     nack1, 3);

        // 4. Request raised mid-frame and dropped before the stop bit ends.
        send(1, 8'h3C, 1'b0);
        check_frame(1, 3, 8);
        chk("mid_busy_end", busy1, 1'b0);
        chk("mid_nack",     nack1, 4);
        repeat (2 * N) @(posedge clk); #1;
        chk("mid_idle_tx",  tx1,   1'b0);
        chk("mid_idle_ack", nack1, 4);

        // 5. Reset in the middle of data bit 3 of 8'hFF.
        send(1, 8'hFF, 1'b0);
        void'(sb_q.pop_back());
        repeat (4 * N + N / 2) @(posedge clk); #1;
        chk("pre_rst_tx", tx1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_tx",   tx1,   1'b0);
        chk("arst_busy", busy1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 3 * N; i++) begin
            @(posedge clk); #1;
            if (tx1 !== 1'b0 || busy1 !== 1'b0 || ack1 !== 1'b0) bad++;
        end
        chk("post_rst_idle", bad, 0);

        // 6. Two stop bits, 8'h5A then back-to-back 8'hC3.
        send(2, 8'h5A, 1'b1);
        t0 = cyc;
        data2 = 8'hC3;
        sb_q.push_back(8'hC3);
        check_frame(2, -1, -1);
        chk("s2_b2b_ack", ack2, 1'b1);
        chk("s2_gap",     cyc - t0, 11 * N);
        req2 = 1'b0;
        check_frame(2, -1, -1);
        chk("s2_busy_end", busy2, 1'b0);
        chk("s2_nack",     nack2, 2);
        chk("sb_empty",    sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
